// File: rtl/gate_test_pkg.sv
// -----------------------------------------------------------------------------
// gate_test_pkg
// Shared constants for the gate self-test slice:
//   - FSM state encoding used by gate_exerciser
//   - number of input combinations driven into a 2-input gate
//   - expected truth tables for common gates; bit index = {a,b}
//   - helper that picks the expected gate output for one combination
// -----------------------------------------------------------------------------
package gate_test_pkg;

    // FSM encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // A 2-input gate has four input combinations
    localparam int NUM_COMBOS = 4;
    localparam int IDX_W      = 2;

    // Expected output tables, bit {a,b}
    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_XOR  = 4'b0110;
    localparam logic [3:0] TT_NAND = 4'b0111;

    // Expected gate output for combination idx under truth table tt
    function automatic logic truth_bit(input logic [3:0] tt, input logic [IDX_W-1:0] idx);
        return tt[idx];
    endfunction

endpackage

// File: rtl/gate_hold_timer.sv
// -----------------------------------------------------------------------------
// gate_hold_timer
// Hold-window counter for gate_exerciser. Counts cycles within the current
// input-combination window and raises last_o during the final cycle of the
// window (count == HOLD_CYCLES-1). last_o is computed from the next count and
// registered, so it lines up exactly with the count register.
// Ports:
//   clk      in  system clock, rising edge
//   rst_n    in  asynchronous active-low reset
//   clear_i  in  restart the window (count returns to 0 at the next edge)
//   en_i     in  advance the count by one at the next edge
//   last_o   out high while the count equals HOLD_CYCLES-1
// -----------------------------------------------------------------------------
module gate_hold_timer
    import gate_test_pkg::*;
#(
    parameter int HOLD_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic en_i,
    output logic last_o
);

    localparam int                CNT_W    = $clog2(HOLD_CYCLES + 1);
    localparam logic [CNT_W-1:0]  LAST_VAL = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             last_q;
    logic             last_d;

    // Next count and look-ahead compare against the window end
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = CNT_ZERO;
        end else if (en_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
        last_d = (cnt_d == LAST_VAL);
    end

    // Count and window-end flag registers; with HOLD_CYCLES=1 every cycle is a window end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= CNT_ZERO;
            last_q <= (LAST_VAL == CNT_ZERO);
        end else begin
            cnt_q  <= cnt_d;
            last_q <= last_d;
        end
    end

    assign last_o = last_q;

endmodule

// File: rtl/gate_exerciser.sv
// -----------------------------------------------------------------------------
// gate_exerciser
// Self-running stimulus/check stage for a 2-input combinational gate. On start
// it drives {a,b} = 00, 01, 10, 11, holding each for HOLD_CYCLES cycles, samples
// gate_out once in the last cycle of each window and compares it with TRUTH.
// Results (mismatch count, per-combination fail flags, pass) hold until the next
// start or reset; done pulses for one cycle when a run completes.
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset (abandons a run, no done)
//   start      in   begin a run; only honoured in IDLE
//   a, b       out  gate inputs
//   gate_out   in   output of the gate under test
//   busy       out  high while a run is in progress
//   done       out  one-cycle pulse at run completion
//   pass       out  last completed run had zero mismatches
//   err_count  out  mismatches in the last or current run (0..4)
//   fail_vec   out  bit i set if combination i mismatched
// -----------------------------------------------------------------------------
module gate_exerciser
    import gate_test_pkg::*;
#(
    parameter int         HOLD_CYCLES = 4,
    parameter logic [3:0] TRUTH       = TT_AND
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       a,
    output logic       b,
    input  logic       gate_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [3:0] fail_vec
);

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] idx_q,   idx_d;
    logic             a_q,     a_d;
    logic             b_q,     b_d;
    logic             busy_q,  busy_d;
    logic             done_q,  done_d;
    logic             pass_q,  pass_d;
    logic [2:0]       err_q,   err_d;
    logic [3:0]       fail_q,  fail_d;

    logic             sample_s;
    logic             timer_clear_s;
    logic             timer_en_s;
    logic             mismatch_s;

    gate_hold_timer #(
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_hold_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (timer_clear_s),
        .en_i    (timer_en_s),
        .last_o  (sample_s)
    );

    // Timer runs only in RUN and restarts at every window end, so it is at 0
    // when a new window (or a new run) begins
    always_comb begin
        timer_en_s    = 1'b0;
        timer_clear_s = 1'b1;
        if (state_q == ST_RUN) begin
            timer_en_s    = 1'b1;
            timer_clear_s = sample_s;
        end else begin
            timer_en_s    = 1'b0;
            timer_clear_s = 1'b1;
        end
    end

    // Compare sampled gate output against the expected table entry
    always_comb begin
        mismatch_s = (gate_out != truth_bit(TRUTH, idx_q));
    end

    // FSM, combination index and scoreboard next-state
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        pass_d  = pass_q;
        err_d   = err_q;
        fail_d  = fail_q;

        case (state_q)
            ST_IDLE: begin
                a_d    = 1'b0;
                b_d    = 1'b0;
                busy_d = 1'b0;
                if (start) begin
                    state_d = ST_RUN;
                    idx_d   = {IDX_W{1'b0}};
                    err_d   = 3'd0;
                    fail_d  = 4'b0000;
                    busy_d  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_RUN: begin
                if (sample_s) begin
                    if (mismatch_s) begin
                        // Four samples at most, so a 3-bit count cannot wrap
                        err_d         = err_q + 3'd1;
                        fail_d[idx_q] = 1'b1;
                    end else begin
                        err_d = err_q;
                    end

                    if (idx_q == IDX_W'(NUM_COMBOS - 1)) begin
                        // pass uses the count including this final sample
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        pass_d  = (err_d == 3'd0);
                        a_d     = 1'b0;
                        b_d     = 1'b0;
                    end else begin
                        idx_d      = idx_q + IDX_W'(1);
                        {a_d, b_d} = idx_d;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end

            ST_DONE: begin
                // Single-cycle state; start is ignored here
                state_d = ST_IDLE;
                a_d     = 1'b0;
                b_d     = 1'b0;
                busy_d  = 1'b0;
            end

            default: begin
                state_d = ST_IDLE;
                idx_d   = {IDX_W{1'b0}};
                a_d     = 1'b0;
                b_d     = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= {IDX_W{1'b0}};
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= 3'd0;
            fail_q  <= 4'b0000;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            fail_q  <= fail_d;
        end
    end

    assign a         = a_q;
    assign b         = b_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_q;
    assign fail_vec  = fail_q;

endmodule

// File: tb/tb_gate_exerciser.sv
// -----------------------------------------------------------------------------
// tb_gate_exerciser
// Two exerciser instances: HOLD=4 checking an AND table, HOLD=1 checking XOR.
// Each drives a behavioural gate model whose table is chosen per run; the HOLD=4
// model can also be "slow" (wrong for all but the last cycle of each window).
// A run model records when each run was accepted and predicts busy/{a,b}/done
// timing plus the final result; results are queued at acceptance and popped
// by the negedge monitor whenever a DUT raises done.
// -----------------------------------------------------------------------------
module tb_gate_exerciser;
    import gate_test_pkg::*;

    localparam int         H0 = 4;
    localparam int         H1 = 1;
    localparam logic [3:0] T0 = TT_AND;
    localparam logic [3:0] T1 = TT_XOR;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;

    logic       start0 = 1'b0, start1 = 1'b0;
    logic       a0, b0, g0, busy0, done0, pass0;
    logic       a1, b1, g1, busy1, done1, pass1;
    logic [2:0] err0, err1;
    logic [3:0] fail0, fail1;

    // Gate models
    logic [3:0] tt0   = 4'b1000;
    logic [3:0] tt1   = 4'b0110;
    logic       slow0 = 1'b0;
    int         age0  = 0;
    logic [2:0] prev0 = 3'b000;

    assign g0 = tt0[{a0, b0}] ^ (slow0 && (age0 < H0 - 1));
    assign g1 = tt1[{a1, b1}];

    gate_exerciser #(.HOLD_CYCLES(H0), .TRUTH(T0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .a(a0), .b(b0), .gate_out(g0),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(err0), .fail_vec(fail0)
    );

    gate_exerciser #(.HOLD_CYCLES(H1), .TRUTH(T1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .gate_out(g1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .fail_vec(fail1)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         k;
        int         done_cyc;
        logic [2:0] err;
        logic [3:0] fail;
        logic       pass;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   next_free[2];
    int   run_s[2];
    bit   run_v[2];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d cyc=%0d", nm, act, exp, cyc);
        end
    endtask

    // Expected result: compare the model's steady-state table with the expected table
    function automatic exp_t predict(input int k, input logic [3:0] model,
                                     input logic [3:0] truth, input int s, input int h);
        exp_t e;
        int   n;
        n      = 0;
        e.fail = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            if (model[i] != truth[i]) begin
                e.fail[i] = 1'b1;
                n++;
            end
        end
        e.k        = k;
        e.err      = 3'(n);
        e.pass     = (n == 0);
        e.done_cyc = s + 4 * h;
        return e;
    endfunction

    task automatic clear_model();
        for (int k = 0; k < 2; k++) begin
            run_v[k]     = 1'b0;
            next_free[k] = 0;
            run_s[k]     = 0;
        end
        q.delete();
    endtask

    // Run model: a run accepted at edge S occupies edges up to S+4H+1,
    // so the next start can be taken at S+4H+2
    always @(posedge clk) begin
        cyc++;
        if (rst_n) begin
            if (start0 && cyc >= next_free[0]) begin
                run_s[0] = cyc; run_v[0] = 1'b1; next_free[0] = cyc + 4 * H0 + 2;
                q.push_back(predict(0, tt0, T0, cyc, H0));
            end
            if (start1 && cyc >= next_free[1]) begin
                run_s[1] = cyc; run_v[1] = 1'b1; next_free[1] = cyc + 4 * H1 + 2;
                q.push_back(predict(1, tt1, T1, cyc, H1));
            end
        end
    end

    // Slow-settle age: cycles since the DUT0 inputs last changed
    always @(negedge clk) begin
        if ({a0, b0, busy0} != prev0) age0 = 0;
        else                          age0 = age0 + 1;
        prev0 = {a0, b0, busy0};
    end

    task automatic mon(input int k, input int h, input logic bz, input logic aa,
                       input logic bb, input logic dn, input logic ps,
                       input logic [2:0] ec, input logic [3:0] fv);
        bit   eb, ed;
        int   ab;
        exp_t e;
        eb = run_v[k] && (cyc >= run_s[k]) && (cyc < run_s[k] + 4 * h);
        ab = eb ? (cyc - run_s[k]) / h : 0;
        ed = run_v[k] && (cyc == run_s[k] + 4 * h);
        chk($sformatf("busy%0d", k), int'(bz), int'(eb));
        chk($sformatf("ab%0d", k), int'({aa, bb}), ab);
        chk($sformatf("done%0d", k), int'(dn), int'(ed));
        if (dn) begin
            if (q.size() == 0 || q[0].k != k) begin
                chk($sformatf("unexpected_done%0d", k), 1, 0);
            end else begin
                e = q.pop_front();
                chk($sformatf("done_cyc%0d", k), cyc, e.done_cyc);
                chk($sformatf("err_count%0d", k), int'(ec), int'(e.err));
                chk($sformatf("fail_vec%0d", k), int'(fv), int'(e.fail));
                chk($sformatf("pass%0d", k), int'(ps), int'(e.pass));
            end
        end
    endtask

    // Monitor: per-cycle timing checks and scoreboard pops on done
    always @(negedge clk) begin
        mon(0, H0, busy0, a0, b0, done0, pass0, err0, fail0);
        mon(1, H1, busy1, a1, b1, done1, pass1, err1, fail1);
    end

    task automatic wait_idle(input int k);
        int n;
        n = 0;
        while (cyc < next_free[k] && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) chk("wait_idle_timeout", 1, 0);
    endtask

    task automatic one_run0(input logic [3:0] tt, input logic slow);
        @(negedge clk);
        tt0 = tt; slow0 = slow; start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        wait_idle(0);
    endtask

    task automatic check_reset_values();
        chk("rst_a0", int'(a0), 0);       chk("rst_b0", int'(b0), 0);
        chk("rst_busy0", int'(busy0), 0); chk("rst_done0", int'(done0), 0);
        chk("rst_pass0", int'(pass0), 0); chk("rst_err0", int'(err0), 0);
        chk("rst_fail0", int'(fail0), 0); chk("rst_busy1", int'(busy1), 0);
        chk("rst_err1", int'(err1), 0);   chk("rst_fail1", int'(fail1), 0);
    endtask

    initial begin
        int n;
        clear_model();
        #1 rst_n = 1'b0;
        #2 check_reset_values();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Directed HOLD=4 runs: good AND, stuck-at-1, slow settle, NAND-like (4 errors)
        one_run0(4'b1000, 1'b0);
        one_run0(4'b1111, 1'b0);
        one_run0(4'b1000, 1'b1);
        one_run0(4'b0111, 1'b0);

        // Reset in the middle of combination 2 of a failing run
        @(negedge clk);
        tt0 = 4'b1111; slow0 = 1'b0; start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        n = 0;
        while (!(run_v[0] && cyc == run_s[0] + 9) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("midrun_wait_timeout", 1, 0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        clear_model();
        #1 check_reset_values();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        one_run0(4'b1000, 1'b0);

        // start held high: back-to-back runs with a one-cycle IDLE gap
        @(negedge clk);
        tt0 = 4'b1001; start0 = 1'b1;
        repeat (60) @(negedge clk);
        start0 = 1'b0;
        wait_idle(0);

        // Random start activity (including pulses during RUN), random gate tables
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!(run_v[0] && cyc < run_s[0] + 4 * H0)) begin
                tt0   = 4'($urandom);
                slow0 = 1'($urandom_range(0, 1));
            end
            start0 = ($urandom_range(0, 3) == 0);
        end
        start0 = 1'b0;
        wait_idle(0);

        // HOLD=1 XOR instance: directed good run, then random
        @(negedge clk);
        tt1 = 4'b0110; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        wait_idle(1);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!(run_v[1] && cyc < run_s[1] + 4 * H1)) tt1 = 4'($urandom);
            start1 = ($urandom_range(0, 2) == 0);
        end
        start1 = 1'b0;
        wait_idle(1);

        repeat (3) @(negedge clk);
        chk("queue_empty", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
